// File: rtl/s_mic_ram_pkg.sv
// Shared MIC packet definitions: type codes, header field positions,
// responder state encoding and a response-header builder.
package s_mic_ram_pkg;

    localparam logic [1:0] MIC_READ  = 2'b00;
    localparam logic [1:0] MIC_WRITE = 2'b01;
    localparam logic [1:0] MIC_RDATA = 2'b10;
    localparam logic [1:0] MIC_WRACK = 2'b11;

    localparam int MIC_BE_HI   = 63;
    localparam int MIC_BE_LO   = 59;
    localparam int MIC_SRC_HI  = 55;
    localparam int MIC_SRC_LO  = 48;
    localparam int MIC_LEN_HI  = 47;
    localparam int MIC_LEN_LO  = 40;
    localparam int MIC_TYPE_HI = 33;
    localparam int MIC_TYPE_LO = 32;
    localparam int MIC_ADDR_HI = 31;
    localparam int MIC_ADDR_LO = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_HDR,
        ST_RD_DATA,
        ST_DROP
    } mic_state_t;

    // Response headers always carry a zero byte-enable field.
    function automatic logic [63:0] mic_hdr(
        input logic [7:0]  src,
        input logic [7:0]  len,
        input logic [1:0]  typ,
        input logic [28:0] addr
    );
        logic [63:0] h;
        h = '0;
        h[MIC_SRC_HI:MIC_SRC_LO]   = src;
        h[MIC_LEN_HI:MIC_LEN_LO]   = len;
        h[MIC_TYPE_HI:MIC_TYPE_LO] = typ;
        h[MIC_ADDR_HI:MIC_ADDR_LO] = addr;
        return h;
    endfunction

endpackage

// File: rtl/s_mic_ram_rng.sv
// 16-bit Galois LFSR used to generate pseudo-random request wait states.
module s_mic_ram_rng #(
    parameter logic [15:0] INIT = 16'hbeef
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] rng
);

    logic [15:0] rng_reg;
    logic [15:0] rng_next;

    // Polynomial x^16+x^14+x^13+x^11+1; a zero seed would lock up, so it is replaced.
    always_comb begin
        rng_next = {1'b0, rng_reg[15:1]} ^ (rng_reg[0] ? 16'hb400 : 16'h0000);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rng_reg <= (INIT == 16'h0000) ? 16'h0001 : INIT;
        end else begin
            rng_reg <= rng_next;
        end
    end

    assign rng = rng_reg;

endmodule

// File: rtl/s_mic_ram.sv
// MIC memory responder: services READ/WRITE request packets against a
// 64-bit wide RAM and returns RDATA/WRACK response packets.
module s_mic_ram
    import s_mic_ram_pkg::*;
#(
    parameter int          ADDR_BITS = 10,
    parameter int          THROTTLE  = 0,
    parameter logic [15:0] RNG_INIT  = 16'hbeef
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        I_TVALID,
    output logic        I_TREADY,
    input  logic [63:0] I_TDATA,
    input  logic        I_TLAST,
    output logic        O_TVALID,
    input  logic        O_TREADY,
    output logic [63:0] O_TDATA,
    output logic        O_TLAST,
    output logic        err,
    output logic [31:0] resp_count
);

    localparam int DEPTH = 1 << ADDR_BITS;

    mic_state_t           state_reg, state_next;
    logic [ADDR_BITS-1:0] ptr_reg, ptr_next;
    logic [7:0]           src_reg, src_next;
    logic [7:0]           len_reg, len_next;
    logic [7:0]           beat_reg, beat_next;
    logic [28:0]          addr_reg, addr_next;
    logic                 err_reg, err_next;
    logic [31:0]          resp_count_reg, resp_count_next;

    logic [63:0] mem [DEPTH];

    logic       rng_gate;
    logic       in_ready_base;
    logic       in_fire;
    logic       out_fire;
    logic       mem_we;
    logic [1:0] hdr_type;

    generate
        if (THROTTLE != 0) begin : g_throttle
            logic [15:0] rng_word;
            logic        rng_unused;

            s_mic_ram_rng #(
                .INIT (RNG_INIT)
            ) u_rng (
                .clk   (clk),
                .reset (reset),
                .rng   (rng_word)
            );

            assign rng_gate   = rng_word[5];
            assign rng_unused = ^{rng_word[15:6], rng_word[4:0]};
        end else begin : g_no_throttle
            assign rng_gate = 1'b1;
        end
    endgenerate

    assign in_ready_base = (state_reg == ST_IDLE) || (state_reg == ST_WR_DATA) ||
                           (state_reg == ST_DROP);
    assign I_TREADY      = in_ready_base & rng_gate;
    assign in_fire       = I_TVALID & I_TREADY;
    assign O_TVALID      = (state_reg == ST_WR_ACK) || (state_reg == ST_RD_HDR) ||
                           (state_reg == ST_RD_DATA);
    assign out_fire      = O_TVALID & O_TREADY;
    assign hdr_type      = I_TDATA[MIC_TYPE_HI:MIC_TYPE_LO];

    // Writes only happen in WR_DATA and reads only in RD_DATA, so the single
    // pointer never serves both at once.
    assign mem_we = (state_reg == ST_WR_DATA) && in_fire && !reset;

    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        src_next        = src_reg;
        len_next        = len_reg;
        beat_next       = beat_reg;
        addr_next       = addr_reg;
        err_next        = err_reg;
        resp_count_next = resp_count_reg;
        O_TDATA         = '0;
        O_TLAST         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (in_fire) begin
                    src_next  = I_TDATA[MIC_SRC_HI:MIC_SRC_LO];
                    len_next  = I_TDATA[MIC_LEN_HI:MIC_LEN_LO];
                    addr_next = I_TDATA[MIC_ADDR_HI:MIC_ADDR_LO];
                    ptr_next  = I_TDATA[ADDR_BITS+2:3];
                    case (hdr_type)
                        MIC_WRITE: begin
                            if (!I_TLAST) begin
                                state_next = ST_WR_DATA;
                            end else begin
                                err_next = 1'b1;
                            end
                        end
                        MIC_READ: begin
                            if (I_TLAST) begin
                                state_next = ST_RD_HDR;
                            end else begin
                                err_next   = 1'b1;
                                state_next = ST_DROP;
                            end
                        end
                        default: begin
                            err_next = 1'b1;
                            if (!I_TLAST) begin
                                state_next = ST_DROP;
                            end
                        end
                    endcase
                end
            end

            ST_WR_DATA: begin
                if (in_fire) begin
                    ptr_next = ptr_reg + 1'b1;
                    if (I_TLAST) begin
                        state_next = ST_WR_ACK;
                    end
                end
            end

            ST_WR_ACK: begin
                O_TDATA = mic_hdr(src_reg, 8'd0, MIC_WRACK, addr_reg);
                O_TLAST = 1'b1;
                if (out_fire) begin
                    state_next      = ST_IDLE;
                    resp_count_next = resp_count_reg + 1'b1;
                end
            end

            ST_RD_HDR: begin
                O_TDATA = mic_hdr(src_reg, len_reg, MIC_RDATA, addr_reg);
                if (out_fire) begin
                    state_next = ST_RD_DATA;
                    beat_next  = 8'd0;
                end
            end

            ST_RD_DATA: begin
                O_TDATA = mem[ptr_reg];
                O_TLAST = (beat_reg == len_reg);
                if (out_fire) begin
                    ptr_next  = ptr_reg + 1'b1;
                    beat_next = beat_reg + 1'b1;
                    if (beat_reg == len_reg) begin
                        state_next      = ST_IDLE;
                        resp_count_next = resp_count_reg + 1'b1;
                    end
                end
            end

            ST_DROP: begin
                if (in_fire && I_TLAST) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            ptr_reg        <= '0;
            src_reg        <= '0;
            len_reg        <= '0;
            beat_reg       <= '0;
            addr_reg       <= '0;
            err_reg        <= 1'b0;
            resp_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            src_reg        <= src_next;
            len_reg        <= len_next;
            beat_reg       <= beat_next;
            addr_reg       <= addr_next;
            err_reg        <= err_next;
            resp_count_reg <= resp_count_next;
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr_reg] <= I_TDATA;
        end
    end

    assign err        = err_reg;
    assign resp_count = resp_count_reg;

endmodule

// File: tb/tb_s_mic_ram.sv
// Directed plus randomized bench for s_mic_ram with request throttling on,
// checked against a flat word-array memory model.
module tb_s_mic_ram;

    localparam int AB    = 10;
    localparam int DEPTH = 1 << AB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        I_TVALID = 1'b0;
    logic        I_TREADY;
    logic [63:0] I_TDATA = '0;
    logic        I_TLAST = 1'b0;
    logic        O_TVALID;
    logic        O_TREADY = 1'b0;
    logic [63:0] O_TDATA;
    logic        O_TLAST;
    logic        err;
    logic [31:0] resp_count;

    s_mic_ram #(
        .ADDR_BITS (AB),
        .THROTTLE  (1),
        .RNG_INIT  (16'hbeef)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .I_TVALID   (I_TVALID),
        .I_TREADY   (I_TREADY),
        .I_TDATA    (I_TDATA),
        .I_TLAST    (I_TLAST),
        .O_TVALID   (O_TVALID),
        .O_TREADY   (O_TREADY),
        .O_TDATA    (O_TDATA),
        .O_TLAST    (O_TLAST),
        .err        (err),
        .resp_count (resp_count)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          exp_resp = 0;
    logic [63:0] ref_mem [DEPTH];
    logic [63:0] wq [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic logic [63:0] req_hdr(input logic [7:0] src, input logic [7:0] len,
                                            input logic [1:0] typ, input logic [31:0] baddr);
        return {5'h1f, 3'b000, src, len, 6'b000000, typ, baddr[31:3], 3'b000};
    endfunction

    function automatic logic [63:0] rsp_hdr(input logic [7:0] src, input logic [7:0] len,
                                            input logic [1:0] typ, input logic [31:0] baddr);
        return {8'h00, src, len, 6'b000000, typ, baddr[31:3], 3'b000};
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_beat(input logic [63:0] d, input logic l);
        int n = 0;
        I_TVALID = 1'b1;
        I_TDATA  = d;
        I_TLAST  = l;
        while (I_TREADY !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("send_timeout", 64'(n < 500), 64'd1);
        @(posedge clk);
        @(negedge clk);
        I_TVALID = 1'b0;
        I_TLAST  = 1'b0;
    endtask

    task automatic recv_beat(input bit rand_rdy, output logic [63:0] d, output logic l);
        int          n = 0;
        bit          held = 0;
        logic [63:0] hd = '0;
        logic        hl = 1'b0;
        while (1) begin
            O_TREADY = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (held) begin
                check("stall_valid", 64'(O_TVALID), 64'd1);
                check("stall_data", O_TDATA, hd);
                check("stall_last", 64'(O_TLAST), 64'(hl));
            end
            if ((O_TVALID === 1'b1 && O_TREADY) || n >= 500) break;
            if (O_TVALID === 1'b1) begin
                held = 1;
                hd   = O_TDATA;
                hl   = O_TLAST;
            end
            @(negedge clk);
            n++;
        end
        check("recv_timeout", 64'(n < 500), 64'd1);
        d = O_TDATA;
        l = O_TLAST;
        @(posedge clk);
        @(negedge clk);
        O_TREADY = 1'b0;
    endtask

    // Writes the contents of wq starting at baddr and checks the acknowledgement.
    task automatic do_write(input logic [31:0] baddr, input logic [7:0] src);
        logic [63:0] d;
        logic        l;
        int          w = int'(baddr[AB+2:3]);
        send_beat(req_hdr(src, 8'(wq.size() - 1), 2'b01, baddr), 1'b0);
        for (int i = 0; i < wq.size(); i++) begin
            send_beat(wq[i], 1'(i == wq.size() - 1));
            ref_mem[(w + i) % DEPTH] = wq[i];
        end
        check("wrack_next_cycle", 64'(O_TVALID), 64'd1);
        recv_beat(1, d, l);
        check("wrack_hdr", d, rsp_hdr(src, 8'd0, 2'b11, baddr));
        check("wrack_last", 64'(l), 64'd1);
        exp_resp++;
        check("resp_count_wr", 64'(resp_count), 64'(exp_resp));
        check("idle_after_wr", 64'(O_TVALID), 64'd0);
        $display("write addr=%h beats=%0d src=%h resp_count=%0d", baddr, wq.size(), src, resp_count);
    endtask

    task automatic do_read(input logic [31:0] baddr, input logic [7:0] len, input logic [7:0] src,
                           input bit rand_rdy);
        logic [63:0] d;
        logic        l;
        int          w = int'(baddr[AB+2:3]);
        send_beat(req_hdr(src, len, 2'b00, baddr), 1'b1);
        check("rdhdr_next_cycle", 64'(O_TVALID), 64'd1);
        recv_beat(rand_rdy, d, l);
        check("rdata_hdr", d, rsp_hdr(src, len, 2'b10, baddr));
        check("rdata_hdr_last", 64'(l), 64'd0);
        for (int i = 0; i <= int'(len); i++) begin
            recv_beat(rand_rdy, d, l);
            check("rdata_beat", d, ref_mem[(w + i) % DEPTH]);
            check("rdata_last", 64'(l), 64'(i == int'(len)));
        end
        exp_resp++;
        check("resp_count_rd", 64'(resp_count), 64'(exp_resp));
        check("idle_after_rd", 64'(O_TVALID), 64'd0);
        $display("read  addr=%h len=%0d src=%h resp_count=%0d", baddr, len, src, resp_count);
    endtask

    initial begin
        logic [63:0] d;
        logic        l;
        logic [31:0] ba;
        int          nb;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_o_tvalid", 64'(O_TVALID), 64'd0);
        check("rst_o_tlast", 64'(O_TLAST), 64'd0);
        check("rst_o_tdata", O_TDATA, 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_resp_count", 64'(resp_count), 64'd0);
        reset = 1'b0;
        $display("reset released");

        // Four-beat write then read-back with random output stalls
        wq = {64'h11, 64'h22, 64'h33, 64'h44};
        do_write(32'h0000_1000, 8'h01);
        do_read(32'h0000_1000, 8'd3, 8'h02, 1);

        // Write across the top word wraps to word 0
        wq = {64'hdead_beef_0000_1023, 64'hcafe_f00d_0000_0000};
        do_write(32'h0000_1ff8, 8'h03);
        do_read(32'h0000_1ff8, 8'd1, 8'h04, 1);
        do_read(32'h0000_0000, 8'd0, 8'h05, 0);
        check("err_clean", 64'(err), 64'd0);

        // READ header without TLAST, followed by two beats to drop
        send_beat(req_hdr(8'h06, 8'd0, 2'b00, 32'h0000_1000), 1'b0);
        check("drop_no_resp0", 64'(O_TVALID), 64'd0);
        send_beat(64'h5555, 1'b0);
        send_beat(64'h6666, 1'b1);
        check("drop_no_resp1", 64'(O_TVALID), 64'd0);
        check("drop_err", 64'(err), 64'd1);
        check("drop_count", 64'(resp_count), 64'(exp_resp));
        $display("malformed read dropped err=%0d", err);
        wq = {64'h7777_0000_0000_0001};
        do_write(32'h0000_2000, 8'h07);

        // WRACK-typed request with TLAST stays idle and writes nothing
        send_beat(req_hdr(8'h08, 8'd0, 2'b11, 32'h0000_1000), 1'b1);
        check("bad_type_no_resp", 64'(O_TVALID), 64'd0);
        check("bad_type_err", 64'(err), 64'd1);
        $display("malformed type ignored err=%0d", err);
        do_read(32'h0000_1000, 8'd3, 8'h09, 0);

        // Reset while the second read data beat is on the bus
        send_beat(req_hdr(8'h0a, 8'd3, 2'b00, 32'h0000_1000), 1'b1);
        recv_beat(0, d, l);
        recv_beat(0, d, l);
        check("pre_rst_beat1", d, 64'h11);
        check("pre_rst_valid", 64'(O_TVALID), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_o_tvalid", 64'(O_TVALID), 64'd0);
        check("midrst_o_tdata", O_TDATA, 64'd0);
        check("midrst_err", 64'(err), 64'd0);
        check("midrst_count", 64'(resp_count), 64'd0);
        exp_resp = 0;
        $display("reset during read data");
        do_read(32'h0000_1000, 8'd3, 8'h0b, 1);

        // Randomized write/read-back pairs from a fresh reset
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_resp = 0;
        for (int t = 0; t < 100; t++) begin
            ba = {19'($urandom), 10'($urandom_range(0, DEPTH - 1)), 3'b000};
            nb = $urandom_range(1, 8);
            wq = {};
            for (int i = 0; i < nb; i++) wq.push_back({$urandom, $urandom});
            do_write(ba, 8'($urandom));
            do_read(ba, 8'($urandom_range(0, nb - 1)), 8'($urandom), 1);
        end
        check("final_resp_count", 64'(resp_count), 64'd200);
        check("final_err", 64'(err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/s_mic_ram.md
S_MIC_RAM -- requirements
Module: s_mic_ram

Interface
REQ-001 Parameter ADDR_BITS, default 10, meaning log2 of memory depth in 64-bit words.
REQ-002 Parameter THROTTLE, default 0, meaning nonzero inserts pseudo-random I_TREADY wait states.
REQ-003 Parameter RNG_INIT, default 16'hbeef, meaning LFSR seed used when THROTTLE is nonzero.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 I_TVALID  in  1  request beat valid.
REQ-007 I_TREADY  out  1  request beat accepted when high with I_TVALID.
REQ-008 I_TDATA  in  64  request beat: header or write data.
REQ-009 I_TLAST  in  1  last beat of request packet.
REQ-010 O_TVALID  out  1  response beat valid.
REQ-011 O_TREADY  in  1  response beat consumed when high with O_TVALID.
REQ-012 O_TDATA  out  64  response beat: header or read data.
REQ-013 O_TLAST  out  1  last beat of response packet.
REQ-014 err  out  1  sticky flag: malformed request seen.
REQ-015 resp_count  out  32  count of completed responses.

Function
REQ-016 Header fields: [63:59] byte enables, [55:48] SRC_ID, [47:40] LEN (beats-1), [33:32] type (00 READ, 01 WRITE, 10 RDATA, 11 WRACK), [31:3] word address; other bits zero.
REQ-017 States: IDLE, WR_DATA, WR_ACK, RD_HDR, RD_DATA, DROP.
REQ-018 I_TREADY high only in IDLE, WR_DATA, DROP (ANDed with rng[5] when THROTTLE is nonzero); low in WR_ACK, RD_HDR, RD_DATA.
REQ-019 Accepted header in IDLE latches SRC_ID, LEN, type, address; word pointer = address[ADDR_BITS+2:3].
REQ-020 WRITE header with I_TLAST=0 -> WR_DATA; each accepted beat writes full 64 bits to mem[ptr], ptr increments modulo 2^ADDR_BITS; byte-enable field ignored.
REQ-021 Write beat with I_TLAST=1 -> WR_ACK; WRACK header presented with O_TVALID=1 on next cycle, O_TLAST=1.
REQ-022 READ header with I_TLAST=1 -> RD_HDR; RDATA header presented next cycle, O_TLAST=0.
REQ-023 Response header: SRC_ID and address echoed from request, LEN echoed for RDATA and zero for WRACK, byte-enable field zero.
REQ-024 RDATA header accepted -> RD_DATA; LEN+1 data beats O_TDATA=mem[ptr] (asynchronous array read), ptr wraps modulo depth, one beat per cycle while O_TREADY=1, O_TLAST=1 on beat LEN+1 only.
REQ-025 O_TVALID/O_TDATA/O_TLAST remain stable while O_TVALID=1 and O_TREADY=0.
REQ-026 Final response beat accepted -> IDLE next cycle, O_TVALID=0, resp_count increments by 1, wrapping at 2^32.
REQ-027 Malformed header (type 10/11, READ with I_TLAST=0, WRITE with I_TLAST=1) sets err; if I_TLAST=0 -> DROP, else stay IDLE; no response, no memory write.
REQ-028 DROP discards beats until one with I_TLAST=1 is accepted, then -> IDLE.
REQ-029 Memory writes during WR_DATA and RD_DATA reads never overlap; read-after-write to same word in a later packet returns new data.

Reset
REQ-030 reset: state=IDLE, O_TVALID=0, O_TLAST=0, O_TDATA=0, err=0, resp_count=0, ptr=0, I_TREADY=1 (THROTTLE=0).
REQ-031 Reset mid-packet abandons it with no response; memory contents are not cleared.

Structure
REQ-032 Packet type codes and header bit positions shall be constants in a shared mic package used by requesters and responders.
REQ-033 The existing rng sub-module shall be instantiated for throttling; no other sub-module.

Verification
REQ-034 WRITE 4 beats (hdr 0x...01_00001000, data 0x11..0x44) -> WRACK header type 11, addr 0x1000, O_TLAST=1, one cycle after last beat; resp_count=1.
REQ-035 READ LEN=3 addr 0x1000 after above -> RDATA header LEN=3, then 0x11,0x22,0x33,0x44, O_TLAST on 4th; O_TREADY toggled randomly, data stable when stalled.
REQ-036 WRITE 2 beats at last word (ADDR_BITS=10, word 1023) -> second beat in word 0; READ LEN=1 returns both in order.
REQ-037 READ header with I_TLAST=0 followed by 2 beats -> err=1, no O_TVALID, next valid WRITE acknowledged normally.
REQ-038 reset asserted during RD_DATA beat 2 -> O_TVALID=0 next cycle, IDLE; subsequent READ returns data written before reset.
REQ-039 THROTTLE=1, 200 random writes/read-backs against m_memtest -> no mismatch, resp_count=200.
